// File: rtl/cpu_pkg.sv
// Shared CPU constants and pipeline-register types.
// Used by the fetch stage and its interface.
package cpu_pkg;

    localparam int          ROM_AW    = 10;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] I_IMM = 7'b0010011;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] S     = 7'b0100011;
    localparam logic [6:0] R     = 7'b0110011;
    localparam logic [6:0] B     = 7'b1100011;

    typedef struct packed {
        logic [31:0] instr1;
        logic [31:0] instr2;
        logic [31:0] pc1;
        logic [31:0] pc2;
        logic        valid1;
        logic        valid2;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_dual_if.sv
// Fetch-stage bus: decode control, ROM address/data and the IF/ID outputs.
// The master side is the fetch stage; the slave side is its environment.
interface fetch_stage_dual_if #(
    parameter int ROM_AW = cpu_pkg::ROM_AW
);
    import cpu_pkg::*;

    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_instr1;
    logic [31:0]       rom_instr2;
    logic [31:0]       if_instr1;
    logic [31:0]       if_instr2;
    logic [31:0]       if_pc1;
    logic [31:0]       if_pc2;
    logic              if_valid1;
    logic              if_valid2;

    modport master (
        input  stall, redirect_valid, redirect_pc, rom_instr1, rom_instr2,
        output rom_addr, if_instr1, if_instr2, if_pc1, if_pc2, if_valid1, if_valid2
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, rom_instr1, rom_instr2,
        input  rom_addr, if_instr1, if_instr2, if_pc1, if_pc2, if_valid1, if_valid2
    );

endinterface

// File: rtl/fetch_pc_gen.sv
// Combinational issue-PC selection, next-PC step and ROM address mux.
// Priority: redirect > stall (replay of the pending pair) > sequential fetch.
module fetch_pc_gen #(
    parameter int ROM_AW = cpu_pkg::ROM_AW
) (
    input  logic              redirect_valid_i,
    input  logic [31:0]       redirect_pc_i,
    input  logic              stall_i,
    input  logic [31:0]       fetch_pc_i,
    input  logic [31:0]       resp_pc_i,
    output logic [31:0]       issue_pc_o,
    output logic [31:0]       next_pc_o,
    output logic              resp_last_o,
    output logic [ROM_AW-1:0] rom_addr_o
);
    import cpu_pkg::*;

    logic [31:0] redirect_aligned;
    logic        issue_last;

    assign redirect_aligned = redirect_pc_i & ~32'h0000_0003;

    always_comb begin
        issue_pc_o = fetch_pc_i;
        if (redirect_valid_i) begin
            issue_pc_o = redirect_aligned;
        end else if (stall_i) begin
            issue_pc_o = resp_pc_i;
        end
    end

    assign rom_addr_o = issue_pc_o[ROM_AW+1:2];

    // The top word has no partner in the ROM, so it is fetched alone and fetch wraps to word 0.
    assign issue_last  = &issue_pc_o[ROM_AW+1:2];
    assign resp_last_o = &resp_pc_i[ROM_AW+1:2];
    assign next_pc_o   = issue_pc_o + (issue_last ? 32'd4 : 32'd8);

endmodule

// File: rtl/fetch_stage_dual.sv
// Dual-issue fetch stage: owns the PC, drives the two-wide ROM and fills IF/ID.
// Stalls replay the pending ROM address; redirects flush IF/ID and restart fetch.
module fetch_stage_dual #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter int          ROM_AW    = cpu_pkg::ROM_AW,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_dual_if.master   bus
);
    import cpu_pkg::*;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    if_id_t      if_id_q, if_id_d;

    logic [31:0] issue_pc;
    logic [31:0] next_pc;
    logic        resp_last;

    fetch_pc_gen #(
        .ROM_AW (ROM_AW)
    ) u_pc_gen (
        .redirect_valid_i (bus.redirect_valid),
        .redirect_pc_i    (bus.redirect_pc),
        .stall_i          (bus.stall),
        .fetch_pc_i       (fetch_pc_q),
        .resp_pc_i        (resp_pc_q),
        .issue_pc_o       (issue_pc),
        .next_pc_o        (next_pc),
        .resp_last_o      (resp_last),
        .rom_addr_o       (bus.rom_addr)
    );

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        resp_valid_d = resp_valid_q;
        resp_pc_d    = resp_pc_q;
        if_id_d      = if_id_q;

        if (bus.redirect_valid) begin
            fetch_pc_d     = next_pc;
            resp_valid_d   = 1'b1;
            resp_pc_d      = issue_pc;
            if_id_d.valid1 = 1'b0;
            if_id_d.valid2 = 1'b0;
            if_id_d.instr1 = NOP_INSTR;
            if_id_d.instr2 = NOP_INSTR;
        end else if (!bus.stall) begin
            fetch_pc_d     = next_pc;
            resp_valid_d   = 1'b1;
            resp_pc_d      = issue_pc;
            // The ROM data on the bus belongs to resp_pc_q, the address issued last cycle.
            if_id_d.pc1    = resp_pc_q;
            if_id_d.pc2    = resp_pc_q + 32'd4;
            if_id_d.valid1 = resp_valid_q;
            if_id_d.valid2 = resp_valid_q && !resp_last;
            if_id_d.instr1 = resp_valid_q ? bus.rom_instr1 : NOP_INSTR;
            if_id_d.instr2 = (resp_valid_q && !resp_last) ? bus.rom_instr2 : NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q     <= RESET_PC;
            resp_valid_q   <= 1'b0;
            resp_pc_q      <= RESET_PC;
            if_id_q.instr1 <= NOP_INSTR;
            if_id_q.instr2 <= NOP_INSTR;
            if_id_q.pc1    <= 32'h0000_0000;
            if_id_q.pc2    <= 32'h0000_0000;
            if_id_q.valid1 <= 1'b0;
            if_id_q.valid2 <= 1'b0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            if_id_q      <= if_id_d;
        end
    end

    assign bus.if_instr1 = if_id_q.instr1;
    assign bus.if_instr2 = if_id_q.instr2;
    assign bus.if_pc1    = if_id_q.pc1;
    assign bus.if_pc2    = if_id_q.pc2;
    assign bus.if_valid1 = if_id_q.valid1;
    assign bus.if_valid2 = if_id_q.valid2;

endmodule

// File: tb/tb_fetch_stage_dual.sv
// Directed bench for the dual-issue fetch stage with a two-wide synchronous ROM model.
module tb_fetch_stage_dual;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_dual_if bus ();

    fetch_stage_dual dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] rom [0:1023];
    logic [9:0]  addr_p1;
    assign addr_p1 = bus.rom_addr + 10'd1;

    always_ff @(posedge clk) begin
        bus.rom_instr1 <= rom[bus.rom_addr];
        bus.rom_instr2 <= rom[addr_p1];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_pair(input string tag, input logic [31:0] pc1, input logic [31:0] i1,
                            input logic [31:0] i2, input logic v1, input logic v2);
        chk({tag, ".pc1"}, bus.if_pc1, pc1);
        chk({tag, ".pc2"}, bus.if_pc2, pc1 + 32'd4);
        chk({tag, ".instr1"}, bus.if_instr1, i1);
        chk({tag, ".instr2"}, bus.if_instr2, i2);
        chk({tag, ".valid1"}, {31'd0, bus.if_valid1}, {31'd0, v1});
        chk({tag, ".valid2"}, {31'd0, bus.if_valid2}, {31'd0, v2});
        $display("pair %s: pc1=%h i1=%h i2=%h v=%b%b", tag, bus.if_pc1, bus.if_instr1,
                 bus.if_instr2, bus.if_valid1, bus.if_valid2);
    endtask

    task automatic chk_flushed(input string tag);
        chk({tag, ".valid1"}, {31'd0, bus.if_valid1}, 32'd0);
        chk({tag, ".valid2"}, {31'd0, bus.if_valid2}, 32'd0);
        chk({tag, ".instr1"}, bus.if_instr1, 32'h0000_0013);
        chk({tag, ".instr2"}, bus.if_instr2, 32'h0000_0013);
        $display("flushed %s: v=%b%b", tag, bus.if_valid1, bus.if_valid2);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = (i << 20) | 32'h0000_0013;
        rom[0]  = 32'h0010_0293;
        rom[1]  = 32'h0020_0313;
        rom[2]  = 32'h0030_0393;
        rom[3]  = 32'h0040_0413;
        rom[10] = 32'h0059_0b33;
        rom[11] = 32'h0123_0bb3;

        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        repeat (3) tick();
        chk("reset.valid1", {31'd0, bus.if_valid1}, 32'd0);
        chk("reset.valid2", {31'd0, bus.if_valid2}, 32'd0);
        chk("reset.instr1", bus.if_instr1, 32'h0000_0013);
        chk("reset.instr2", bus.if_instr2, 32'h0000_0013);
        chk("reset.pc1", bus.if_pc1, 32'h0);
        chk("reset.pc2", bus.if_pc2, 32'h0);
        chk("reset.rom_addr", {22'd0, bus.rom_addr}, 32'd0);

        rst = 1'b0;
        tick();
        chk("boot1.valid1", {31'd0, bus.if_valid1}, 32'd0);
        tick();
        chk_pair("boot2", 32'h0, 32'h0010_0293, 32'h0020_0313, 1'b1, 1'b1);
        tick();
        chk_pair("boot3", 32'h8, 32'h0030_0393, 32'h0040_0413, 1'b1, 1'b1);
        tick();
        chk_pair("seq10", 32'h10, rom[4], rom[5], 1'b1, 1'b1);

        // Stall for three edges with pc1=0x10 in IF/ID.
        bus.stall = 1'b1;
        #1;
        chk("stall.rom_addr", {22'd0, bus.rom_addr}, 32'd6);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_pair("stall_hold", 32'h10, rom[4], rom[5], 1'b1, 1'b1);
            chk("stall_hold.rom_addr", {22'd0, bus.rom_addr}, 32'd6);
        end
        bus.stall = 1'b0;
        tick();
        chk_pair("unstall18", 32'h18, rom[6], rom[7], 1'b1, 1'b1);
        tick();
        chk_pair("unstall20", 32'h20, rom[8], rom[9], 1'b1, 1'b1);

        // Redirect to 0x28.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h28;
        #1;
        chk("redir28.rom_addr", {22'd0, bus.rom_addr}, 32'd10);
        tick();
        bus.redirect_valid = 1'b0;
        chk_flushed("redir28_flush");
        tick();
        chk_pair("redir28", 32'h28, 32'h0059_0b33, 32'h0123_0bb3, 1'b1, 1'b1);
        tick();
        chk_pair("redir30", 32'h30, rom[12], rom[13], 1'b1, 1'b1);

        // Redirect to the top ROM word.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFC;
        #1;
        chk("top.rom_addr", {22'd0, bus.rom_addr}, 32'd1023);
        tick();
        bus.redirect_valid = 1'b0;
        chk_flushed("top_flush");
        tick();
        chk_pair("top_ffc", 32'hFFC, 32'h3FF0_0013, 32'h0000_0013, 1'b1, 1'b0);
        tick();
        chk_pair("top_wrap", 32'h1000, 32'h0010_0293, 32'h0020_0313, 1'b1, 1'b1);

        // Redirect and stall together, stall held afterwards.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.stall          = 1'b1;
        #1;
        chk("rs.rom_addr", {22'd0, bus.rom_addr}, 32'd16);
        tick();
        bus.redirect_valid = 1'b0;
        chk_flushed("rs_flush");
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_flushed("rs_hold");
            chk("rs_hold.rom_addr", {22'd0, bus.rom_addr}, 32'd16);
        end
        bus.stall = 1'b0;
        tick();
        chk_pair("rs_40", 32'h40, 32'h0100_0013, 32'h0110_0013, 1'b1, 1'b1);
        tick();
        chk_pair("rs_48", 32'h48, 32'h0120_0013, 32'h0130_0013, 1'b1, 1'b1);

        // Asynchronous reset mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid1", {31'd0, bus.if_valid1}, 32'd0);
        chk("arst.valid2", {31'd0, bus.if_valid2}, 32'd0);
        chk("arst.pc1", bus.if_pc1, 32'h0);
        chk("arst.instr1", bus.if_instr1, 32'h0000_0013);
        chk("arst.rom_addr", {22'd0, bus.rom_addr}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rboot1.valid1", {31'd0, bus.if_valid1}, 32'd0);
        tick();
        chk_pair("rboot2", 32'h0, 32'h0010_0293, 32'h0020_0313, 1'b1, 1'b1);
        tick();
        chk_pair("rboot3", 32'h8, 32'h0030_0393, 32'h0040_0413, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage_dual.md
Name: fetch_stage_dual

Overview:
Dual-issue instruction fetch stage. Owns the PC and drives the word address of the synchronous two-wide instruction ROM (registered outputs, 1-cycle read latency, returns rom[addr] and rom[addr+1]). Captures each ROM pair into the IF/ID pipeline register with per-slot PC and valid bits for the dual decoder. Handles decode stalls by address replay and handles branch/JAL redirects by flushing.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset.
ROM_AW, 10, ROM word-address width (1024 words).
NOP_INSTR, 32'h0000_0013, value held in instruction slots when invalid (addi x0,x0,0).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
stall  input  1  decode/hazard unit cannot accept; hold IF/ID.
redirect_valid  input  1  redirect request from branch/JAL resolution.
redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0.
rom_addr  output  ROM_AW  word address to ROM (combinational).
rom_instr1  input  32  ROM slot-1 data (word rom_addr of previous cycle).
rom_instr2  input  32  ROM slot-2 data (word rom_addr+1 of previous cycle).
if_instr1  output  32  IF/ID slot-1 instruction.
if_instr2  output  32  IF/ID slot-2 instruction.
if_pc1  output  32  byte PC of slot 1.
if_pc2  output  32  byte PC of slot 2 (if_pc1+4).
if_valid1  output  1  slot 1 holds a real instruction.
if_valid2  output  1  slot 2 holds a real instruction.

Behaviour:
- State: fetch_pc (next PC to issue); resp_valid, resp_pc (tag of the pair currently on rom_instr*); IF/ID register.
- Reset (async, immediate): fetch_pc=RESET_PC; resp_valid=0; resp_pc=RESET_PC; if_instr1/2=NOP_INSTR; if_pc1=0; if_pc2=0; if_valid1/2=0.
- The address issue path has three cases. Priority is redirect > stall > normal.
  - redirect_valid: rom_addr=redirect_pc[ROM_AW+1:2]. At the clock edge, fetch_pc=redirect_pc+step(redirect_pc), resp_valid=1, resp_pc=redirect_pc, if_valid1/2=0, and if_instr1/2=NOP_INSTR. This applies even when stall=1.
  - stall (no redirect): rom_addr=resp_pc[ROM_AW+1:2] (replay, so the ROM re-emits the pending pair). fetch_pc, resp_*, and IF/ID all hold.
  - normal: rom_addr=fetch_pc[ROM_AW+1:2]. At the clock edge, fetch_pc=fetch_pc+step(fetch_pc), resp_valid=1, and resp_pc=fetch_pc. IF/ID loads: if_instr1/2=rom_instr1/2, if_pc1=resp_pc, if_pc2=resp_pc+4, if_valid1=resp_valid, if_valid2=resp_valid && !last(resp_pc). Any invalid slot loads NOP_INSTR.
- last(pc) is true when pc[ROM_AW+1:2] is all ones (word 1023). step(pc) is 4 if last(pc), otherwise 8. The pair at the top word therefore never uses rom[addr+1], and fetch continues at word 0.
- Latency:
  - Reset release to first valid IF/ID is 2 cycles.
  - Redirect to valid target pair in IF/ID is 2 cycles (the redirect edge flushes, the next edge loads).
  - Steady state: one pair (8 bytes) per cycle.
- PC arithmetic is 32-bit modulo 2^32. The ROM index uses only bits [ROM_AW+1:2].
- Stall never drops or duplicates an instruction: the pair pending at stall assertion is the first one loaded after release.

Decomposition:
- Shared package cpu_pkg holds:
  - NOP_INSTR, RESET_PC, ROM_AW, and the opcode localparams (I_IMM, LOAD, JAL, S, R, B).
  - An if_id_t struct {instr1, instr2, pc1, pc2, valid1, valid2}.
- One sub-module, fetch_pc_gen: next-PC/step/last logic and the rom_addr mux (combinational). The top holds the registers.

Test Plan:
- Reset, hold rst 3 cycles, release; ROM words 0..15 as addi/add program → cycle 2: if_pc1=0, if_valid1/2=1, if_instr1=0x00100293, if_instr2=0x00200313; cycle 3: if_pc1=8, instr 0x00300393/0x00400413.
- stall high 3 cycles while IF/ID shows pc1=0x10 → IF/ID frozen at pc1=0x10 and rom_addr=6 during the stall; first pair after release has pc1=0x18; no pair skipped or repeated.
- redirect_valid 1 cycle, redirect_pc=0x28 → next cycle if_valid1/2=0 and NOPs; following cycle pc1=0x28, instr1=rom[10]=0x00590b33, instr2=0x01230bb3.
- redirect_pc=0xFFC (word 1023) → pair at pc1=0xFFC has valid1=1, valid2=0; next pair pc1=0x1000 (rom[0], rom[1]) both valid.
- redirect and stall asserted together → redirect wins: flush, rom_addr=target word; with stall held afterwards, IF/ID stays invalid until release, then the target pair appears.
- Assert rst mid-stream at an arbitrary phase → outputs reset immediately (asynchronously, before the next edge); the fetch sequence restarts from RESET_PC with 2-cycle latency.
